// File: rtl/reg_file_dual_read.sv
// rtl/reg_file_dual_read.sv - register file with two registered read ports, byte-enabled write, forwarding and clear sweep
module reg_file_dual_read #(
    parameter int width          = 32,
    parameter int widthad        = 5,
    parameter int zero_reg       = 1,
    parameter int clear_on_reset = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 ready,
    input  logic                 rd_en,
    input  logic [widthad-1:0]   address_a,
    output logic [width-1:0]     q_a,
    input  logic [widthad-1:0]   address_b,
    output logic [width-1:0]     q_b,
    input  logic [widthad-1:0]   address_w,
    input  logic                 wren_w,
    input  logic [width/8-1:0]   byteena_w,
    input  logic [width-1:0]     data_w
);

    localparam int depth  = 1 << widthad;
    localparam int nbytes = width / 8;
    localparam logic [widthad:0] last_idx = (widthad + 1)'(depth - 1);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t             state, state_n;
    logic [widthad:0]   counter;
    logic               clr_we;
    logic               wr_eff;
    logic [width-1:0]   merged;
    logic [width-1:0]   rdata_a, rdata_b;
    logic [width-1:0]   mem [depth];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= CLEAR;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        clr_we  = 1'b0;
        case (state)
            CLEAR: begin
                if (clear_on_reset != 0) begin
                    clr_we = 1'b1;
                    if (counter == last_idx) begin
                        state_n = RUN;
                    end
                end else begin
                    state_n = RUN;
                end
            end
            RUN:     state_n = RUN;
            default: state_n = CLEAR;
        endcase
    end

    // counter is one bit wider than the address so the sweep never wraps
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter <= '0;
            ready   <= 1'b0;
        end else begin
            if (clr_we) begin
                counter <= counter + 1'b1;
            end
            ready <= (state_n == RUN);
        end
    end

    assign wr_eff = (state == RUN) && wren_w && !((zero_reg != 0) && (address_w == '0));

    always_comb begin
        merged = mem[address_w];
        for (int i = 0; i < nbytes; i++) begin
            if (byteena_w[i]) begin
                merged[8*i +: 8] = data_w[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[counter[widthad-1:0]] <= '0;
        end else if (wr_eff) begin
            mem[address_w] <= merged;
        end
    end

    always_comb begin
        rdata_a = mem[address_a];
        if ((zero_reg != 0) && (address_a == '0)) begin
            rdata_a = '0;
        end else if (wr_eff && (address_w == address_a)) begin
            rdata_a = merged;
        end
    end

    always_comb begin
        rdata_b = mem[address_b];
        if ((zero_reg != 0) && (address_b == '0)) begin
            rdata_b = '0;
        end else if (wr_eff && (address_w == address_b)) begin
            rdata_b = merged;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_a <= '0;
            q_b <= '0;
        end else if (state == CLEAR) begin
            q_a <= '0;
            q_b <= '0;
        end else if (rd_en) begin
            q_a <= rdata_a;
            q_b <= rdata_b;
        end
    end

endmodule

// File: tb/tb_reg_file_dual_read.sv
// tb/tb_reg_file_dual_read.sv - scoreboard bench for reg_file_dual_read
module tb_reg_file_dual_read;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd_en, wren_w;
    logic [4:0]  address_a, address_b, address_w;
    logic [3:0]  byteena_w;
    logic [31:0] data_w;
    logic [31:0] q_a0, q_b0, q_a1, q_b1;
    logic        ready0, ready1;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] qa0;
        logic [31:0] qb0;
        logic [31:0] qa1;
        logic [31:0] qb1;
        logic        r0;
        logic        r1;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mm [2][32];
    logic [31:0] m_qa [2];
    logic [31:0] m_qb [2];
    logic        m_run [2];
    int          m_cnt [2];

    // instance 0: zero register and clear sweep; instance 1: neither
    reg_file_dual_read #(.width(32), .widthad(5), .zero_reg(1), .clear_on_reset(1)) dut0 (
        .clk(clk), .reset(reset), .ready(ready0), .rd_en(rd_en),
        .address_a(address_a), .q_a(q_a0), .address_b(address_b), .q_b(q_b0),
        .address_w(address_w), .wren_w(wren_w), .byteena_w(byteena_w), .data_w(data_w)
    );

    reg_file_dual_read #(.width(32), .widthad(5), .zero_reg(0), .clear_on_reset(0)) dut1 (
        .clk(clk), .reset(reset), .ready(ready1), .rd_en(rd_en),
        .address_a(address_a), .q_a(q_a1), .address_b(address_b), .q_b(q_b1),
        .address_w(address_w), .wren_w(wren_w), .byteena_w(byteena_w), .data_w(data_w)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_run[k] = 1'b0;
            m_cnt[k] = 0;
            m_qa[k]  = '0;
            m_qb[k]  = '0;
        end
    endtask

    function automatic logic [31:0] model_read(input int k, input logic [4:0] a,
                                               input logic eff, input logic [31:0] mrg);
        if (k == 0 && a == 5'd0) return 32'h0;
        if (eff && a == address_w) return mrg;
        return mm[k][a];
    endfunction

    task automatic model_edge(input int k);
        logic [31:0] mrg;
        logic        eff;
        if (!m_run[k]) begin
            m_qa[k] = '0;
            m_qb[k] = '0;
            if (k == 0) begin
                mm[k][m_cnt[k]] = '0;
                if (m_cnt[k] == 31) m_run[k] = 1'b1;
                m_cnt[k]++;
            end else begin
                m_run[k] = 1'b1;
            end
        end else begin
            eff = wren_w && !(k == 0 && address_w == 5'd0);
            mrg = mm[k][address_w];
            for (int i = 0; i < 4; i++)
                if (byteena_w[i]) mrg[8*i +: 8] = data_w[8*i +: 8];
            if (rd_en) begin
                m_qa[k] = model_read(k, address_a, eff, mrg);
                m_qb[k] = model_read(k, address_b, eff, mrg);
            end
            if (eff) mm[k][address_w] = mrg;
        end
    endtask

    task automatic cycle(input logic re, input logic [4:0] aa, input logic [4:0] ab,
                         input logic [4:0] aw, input logic we, input logic [3:0] be,
                         input logic [31:0] d);
        exp_t e;
        rd_en = re; address_a = aa; address_b = ab;
        address_w = aw; wren_w = we; byteena_w = be; data_w = d;
        model_edge(0);
        model_edge(1);
        e.qa0 = m_qa[0]; e.qb0 = m_qb[0]; e.r0 = m_run[0];
        e.qa1 = m_qa[1]; e.qb1 = m_qb[1]; e.r1 = m_run[1];
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("q_a zr", q_a0, e.qa0);
        chk("q_b zr", q_b0, e.qb0);
        chk("ready zr", {31'b0, ready0}, {31'b0, e.r0});
        chk("q_a nz", q_a1, e.qa1);
        chk("q_b nz", q_b1, e.qb1);
        chk("ready nz", {31'b0, ready1}, {31'b0, e.r1});
        @(negedge clk);
    endtask

    task automatic do_reset(input int hold);
        reset = 1'b1;
        #1;
        model_reset();
        chk("rst q_a zr", q_a0, 32'h0);
        chk("rst q_b zr", q_b0, 32'h0);
        chk("rst ready zr", {31'b0, ready0}, 32'h0);
        chk("rst q_a nz", q_a1, 32'h0);
        chk("rst ready nz", {31'b0, ready1}, 32'h0);
        repeat (hold) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic sweep_check(input string tag, input logic [4:0] aw, input logic we);
        for (int i = 0; i < 32; i++) begin
            cycle(1'b0, 5'd0, 5'd0, aw, we, 4'hF, 32'h5A5A5A5A);
            chk(tag, {31'b0, ready0}, 32'(i == 31));
        end
    endtask

    initial begin
        logic [4:0] ra, rb, rw;
        reset = 1'b0; rd_en = 1'b0; wren_w = 1'b0;
        address_a = '0; address_b = '0; address_w = '0; byteena_w = '0; data_w = '0;
        #2;
        do_reset(2);
        sweep_check("sweep1 ready", 5'd0, 1'b0);

        for (int i = 0; i < 32; i++) cycle(1'b0, 5'd0, 5'd0, 5'(i), 1'b1, 4'hF, $urandom);
        do_reset(1);
        sweep_check("sweep2 ready", 5'd0, 1'b0);
        for (int i = 0; i < 32; i++) begin
            cycle(1'b1, 5'(i), 5'(31 - i), 5'd0, 1'b0, 4'h0, 32'h0);
            chk("cleared q_a", q_a0, 32'h0);
            chk("cleared q_b", q_b0, 32'h0);
        end

        cycle(1'b0, 5'd0, 5'd0, 5'd5, 1'b1, 4'hF, 32'h11223344);
        cycle(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 4'h0, 32'h0);
        cycle(1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 4'b0101, 32'hAABBCCDD);
        chk("fwd q_a", q_a0, 32'h11BB33DD);
        chk("fwd q_b", q_b0, 32'h11BB33DD);
        chk("fwd q_a nz", q_a1, 32'h11BB33DD);
        cycle(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 4'h0, 32'h0);
        chk("fwd reread", q_a0, 32'h11BB33DD);
        cycle(1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 4'h0, 32'hFFFFFFFF);
        chk("be0 noop", q_b0, 32'h11BB33DD);

        cycle(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 4'hF, 32'hFFFFFFFF);
        chk("zero same edge", q_a0, 32'h0);
        chk("nozero same edge", q_a1, 32'hFFFFFFFF);
        cycle(1'b1, 5'd0, 5'd1, 5'd0, 1'b0, 4'h0, 32'h0);
        chk("zero later", q_a0, 32'h0);
        chk("nozero later", q_a1, 32'hFFFFFFFF);

        cycle(1'b0, 5'd0, 5'd0, 5'd3, 1'b1, 4'hF, 32'h12345678);
        cycle(1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 4'h0, 32'h0);
        chk("hold load", q_a0, 32'h12345678);
        cycle(1'b0, 5'd7, 5'd7, 5'd7, 1'b1, 4'hF, 32'hCAFEBABE);
        chk("hold 1", q_a0, 32'h12345678);
        cycle(1'b0, 5'd7, 5'd7, 5'd0, 1'b0, 4'h0, 32'h0);
        chk("hold 2", q_a0, 32'h12345678);
        cycle(1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 4'h0, 32'h0);
        chk("hold release", q_a0, 32'hCAFEBABE);

        do_reset(1);
        repeat (10) cycle(1'b0, 5'd0, 5'd0, 5'd9, 1'b1, 4'hF, 32'hDEADBEEF);
        do_reset(1);
        sweep_check("midsweep ready", 5'd9, 1'b1);
        cycle(1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 4'h0, 32'h0);
        chk("sweep write ignored", q_a0, 32'h0);

        for (int n = 0; n < 10000; n++) begin
            rw = 5'($urandom_range(0, 31));
            ra = ($urandom_range(0, 3) == 0) ? rw : 5'($urandom_range(0, 31));
            rb = ($urandom_range(0, 3) == 0) ? rw : 5'($urandom_range(0, 31));
            cycle(($urandom_range(0, 4) != 0), ra, rb, rw, ($urandom_range(0, 1) == 1),
                  4'($urandom), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_file_dual_read.md
# reg_file_dual_read

Parametrised register-file RAM with two registered read ports, one byte-enabled write port, and write-to-read forwarding on both read ports. It is the successor to the single-read simple dual-port RAM and backs the CPU's general-purpose register file and similar multi-read tables. It adds three things: an optional hardwired-zero entry 0, a read-hold enable for pipeline stalls, and a post-reset clear sweep that zeroes every entry before the block reports ready.

## Interface
Parameters:
- width, 32, data width in bits; must be a multiple of 8.
- widthad, 5, address width; depth D = 2**widthad.
- zero_reg, 1, when 1: address 0 always reads 0 and writes to address 0 are discarded.
- clear_on_reset, 1, when 1: run a clear sweep after reset; when 0: no sweep.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- ready  out  1  high when the array is initialised and accepting writes.
- rd_en  in  1  read enable; when low, q_a and q_b hold their values.
- address_a  in  widthad  read port A address.
- q_a  out  width  read port A data, registered.
- address_b  in  widthad  read port B address.
- q_b  out  width  read port B data, registered.
- address_w  in  widthad  write address.
- wren_w  in  1  write strobe.
- byteena_w  in  width/8  byte enables; bit i covers data bits [8i+7:8i].
- data_w  in  width  write data.

## Operation
- States: CLEAR and RUN.
- Reset values: state = CLEAR, sweep counter = 0, ready = 0, q_a = 0, q_b = 0. Array contents are not reset asynchronously.
- CLEAR with clear_on_reset = 1:
  - Each edge writes 0 to mem[counter], then increments the counter.
  - After writing entry D-1, the block moves to RUN and ready goes to 1.
  - wren_w is ignored.
  - q_a and q_b are forced to 0.
- CLEAR with clear_on_reset = 0: the first edge after reset release moves to RUN and sets ready = 1. Nothing is written.
- RUN, write path:
  - When wren_w = 1, for each i with byteena_w[i] = 1, byte i of mem[address_w] takes byte i of data_w. Other bytes are unchanged.
  - The write is suppressed when zero_reg = 1 and address_w = 0.
- RUN, read path (ports A and B are independent and identical):
  - If rd_en = 0, q holds.
  - Else if zero_reg = 1 and the port address = 0, q <= 0.
  - Else if an effective write occurs this edge to the same address, q <= the merged word: enabled bytes from data_w, the remaining bytes from the old mem contents.
  - Otherwise q <= mem[address].
- Simultaneous events:
  - Both read ports may address the same entry, including the entry being written; both then receive identical forwarded data.
  - wren_w with byteena_w = 0 is a no-op and forwards the old word.
- Reset during CLEAR or RUN: reset takes effect immediately. When reset is released, the sweep restarts from counter 0. Any write in flight on the reset edge is lost.

## Timing
- Read latency: 1 cycle. The address presented before edge N produces data on q after edge N.
- Write: committed at the edge. A read of the same address on the same edge sees the new data through forwarding. A read on a later edge sees it from the array.
- Clear sweep: exactly D edges after reset release. ready is 1 after edge D (edge 1 is the first edge with reset low). A write presented at edge D+1 is accepted.
- ready is a registered output. In RUN it stays 1 until the next reset.
- The counter is widthad+1 bits wide, or uses a terminal compare at D-1, so that no wrap-around rewrite occurs.

## Test plan
- Reset then sweep: pre-load the array with garbage (clear_on_reset = 1, widthad = 5), pulse reset, then release.
  - ready must stay 0 for 31 edges and go to 1 after edge 32.
  - Reading addresses 0..31 then returns 0x00000000 everywhere.
- Forwarding with byte merge:
  - Write mem[5] = 0x11223344, then idle.
  - Next, write address_w = 5, byteena_w = 4'b0101, data_w = 0xAABBCCDD, with address_a = address_b = 5 and rd_en = 1 on the same edge.
  - q_a = q_b = 0x11BB33DD on that edge; the next read of 5 also returns 0x11BB33DD.
- Zero register:
  - Write 0xFFFFFFFF to address 0 while address_a = 0.
  - q_a must be 0 on that edge and on a later read.
  - With zero_reg = 0, the same sequence returns 0xFFFFFFFF.
- Read hold: q_a = 0x12345678 from address 3; drop rd_en and change address_a to 7 while writing to 7. q_a must stay 0x12345678 until rd_en returns high.
- Reset mid-sweep: assert reset at sweep edge 10, then release.
  - ready must rise only after a full 32 edges.
  - A wren_w during the sweep must leave its target reading 0.
- Back-to-back random traffic: writes and dual reads on every edge for 10k cycles, checked against a reference model with byte merge, forwarding and zero-register rules.
